// File: rtl/imem_loader.sv
// imem_loader: writes a program byte stream little-endian into instruction memory, pads to a word
// boundary and stalls fetch while loading. Define IMEM_LOADER_CHECKSUM_EN to treat the last byte as a checksum.
module imem_loader #(
    parameter int MEM_BYTES = 128,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              hold_fetch,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W-1:0] byte_count
);
    typedef enum logic [2:0] {IDLE, LOAD, PAD, DONE, ERR} state_t;

    localparam logic [ADDR_W-1:0] MEM_END = ADDR_W'(MEM_BYTES);

    state_t            state;
    logic [ADDR_W-1:0] next_count;
    logic              full;

    assign next_count = byte_count + ADDR_W'(1);
    // Overflow is decided before the write, so the address never reaches past the memory.
    assign full       = (byte_count == MEM_END);

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] sum;
    logic [7:0] sum_next;
    assign sum_next = sum + in_data;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            hold_fetch <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            byte_count <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum        <= '0;
`endif
        end else begin
            wr_en     <= 1'b0;
            load_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= LOAD;
                        in_ready   <= 1'b1;
                        hold_fetch <= 1'b1;
                        byte_count <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum        <= '0;
`endif
                    end
                end
                LOAD: begin
                    if (in_valid && in_ready) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        // The checksum beat is never written, so it cannot overflow.
                        if (in_last) begin
                            in_ready <= 1'b0;
                            if (sum_next != 8'h00) begin
                                state    <= ERR;
                                load_err <= 1'b1;
                            end else if (byte_count[1:0] == 2'b00) begin
                                state     <= DONE;
                                load_done <= 1'b1;
                            end else begin
                                state <= PAD;
                            end
                        end else if (full) begin
                            state    <= ERR;
                            in_ready <= 1'b0;
                            load_err <= 1'b1;
                        end else begin
                            wr_en      <= 1'b1;
                            wr_addr    <= byte_count;
                            wr_data    <= in_data;
                            byte_count <= next_count;
                            sum        <= sum_next;
                        end
`else
                        if (full) begin
                            state    <= ERR;
                            in_ready <= 1'b0;
                            load_err <= 1'b1;
                        end else begin
                            wr_en      <= 1'b1;
                            wr_addr    <= byte_count;
                            wr_data    <= in_data;
                            byte_count <= next_count;
                            if (in_last) begin
                                in_ready <= 1'b0;
                                if (next_count[1:0] == 2'b00) begin
                                    state     <= DONE;
                                    load_done <= 1'b1;
                                end else begin
                                    state <= PAD;
                                end
                            end
                        end
`endif
                    end
                end
                PAD: begin
                    wr_en      <= 1'b1;
                    wr_addr    <= byte_count;
                    wr_data    <= 8'h00;
                    byte_count <= next_count;
                    if (next_count[1:0] == 2'b00) begin
                        state     <= DONE;
                        load_done <= 1'b1;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    hold_fetch <= 1'b0;
                end
                ERR: begin
                    if (start) begin
                        state      <= LOAD;
                        in_ready   <= 1'b1;
                        load_err   <= 1'b0;
                        byte_count <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum        <= '0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader; expected memory writes come from a stream-level model.
module tb_imem_loader;
    localparam int MEM = 8;
    localparam int AW  = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_last = 1'b0;
    logic          in_ready, wr_en, hold_fetch, load_done, load_err;
    logic [AW-1:0] wr_addr, byte_count;
    logic [7:0]    wr_data;

    imem_loader #(.MEM_BYTES(MEM), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .hold_fetch(hold_fetch), .load_done(load_done),
        .load_err(load_err), .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] stream[$];
    bit         beat_wr[$];
    int         sent;
    bit         exp_err;
    int         exp_count;
    int         n_tests = 0;
    int         n_fail = 0;
    int         done_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every write strobe must match the next expected write.
    always @(negedge clk) begin
        if (load_done) done_cnt++;
        if (reset && wr_en) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected write: addr %0h data %0h, expected none", wr_addr, wr_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write addr", 64'(wr_addr), 64'(e.addr));
                check("write data", 64'(wr_data), 64'(e.data));
            end
        end
    end

    // Stream-level reference: which beats are consumed, what lands in memory, and how the load ends.
    task automatic model();
        logic [7:0] sum;
        int n, cnt;
        n = stream.size();
        sum = 8'h00;
        cnt = 0;
        exp_err = 0;
        sent = n;
        beat_wr.delete();
        for (int i = 0; i < n; i++) begin
            sum = sum + stream[i];
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (i == n - 1) begin
                beat_wr.push_back(1'b0);
                if (sum != 8'h00) exp_err = 1;
                break;
            end
`endif
            if (cnt == MEM) begin
                beat_wr.push_back(1'b0);
                exp_err = 1;
                sent = i + 1;
                break;
            end
            exp_q.push_back('{addr: AW'(cnt), data: stream[i]});
            beat_wr.push_back(1'b1);
            cnt++;
        end
        if (!exp_err) begin
            while (cnt % 4 != 0) begin
                exp_q.push_back('{addr: AW'(cnt), data: 8'h00});
                cnt++;
            end
        end
        exp_count = cnt;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("hold_fetch after start", 64'(hold_fetch), 64'd1);
        check("in_ready after start", 64'(in_ready), 64'd1);
        check("byte_count after start", 64'(byte_count), 64'd0);
        check("load_err after start", 64'(load_err), 64'd0);
    endtask

    task automatic send_beat(input logic [7:0] d, input bit last, input bit exp_wr,
                             input bit bubbles, input bit glitch);
        if (bubbles) begin
            repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                start = glitch && ($urandom_range(0, 1) == 1);
                in_data = 8'($urandom);
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        check("in_ready in LOAD", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_data = d;
        in_last = last;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last = 1'b0;
        check("wr_en after accept", 64'(wr_en), 64'(exp_wr));
    endtask

    task automatic run_txn(input bit bubbles, input bit glitch);
        int d0, w;
        model();
        d0 = done_cnt;
        pulse_start();
        for (int i = 0; i < sent; i++)
            send_beat(stream[i], i == stream.size() - 1, beat_wr[i], bubbles, glitch);
        if (glitch && !exp_err) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        w = 0;
        while (hold_fetch && !load_err && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        repeat (2) @(posedge clk);
        #1;
        check("load_done pulses", 64'(done_cnt - d0), exp_err ? 64'd0 : 64'd1);
        check("load_err", 64'(load_err), 64'(exp_err));
        check("hold_fetch at end", 64'(hold_fetch), 64'(exp_err));
        check("byte_count at end", 64'(byte_count), 64'(exp_count));
        check("in_ready at end", 64'(in_ready), 64'd0);
        check("pending writes", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic set_stream(input logic [63:0] bytes, input int n);
        logic [63:0] b;
        b = bytes;
        stream.delete();
        for (int i = 0; i < n; i++) stream.push_back(b[8*i +: 8]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", 64'(in_ready), 64'd0);
        check("reset wr_en", 64'(wr_en), 64'd0);
        check("reset hold_fetch", 64'(hold_fetch), 64'd0);
        check("reset load_err", 64'(load_err), 64'd0);
        check("reset byte_count", 64'(byte_count), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        // Two words back-to-back, exactly filling memory
        set_stream(64'h0010_0093_0000_0013, 8);
        run_txn(0, 0);

        // Five bytes with bubbles and start pulses in LOAD and PAD
        set_stream(64'h0000_0055_4433_2211, 5);
        run_txn(1, 1);

        // Overflow, then recovery from ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
        set_stream(64'h0807_0605_0403_0201, 8);
        stream.push_back(8'h09);
        stream.push_back(8'h0A);
`else
        set_stream(64'h0807_0605_0403_0201, 8);
        stream.push_back(8'h09);
`endif
        run_txn(0, 0);
        set_stream(64'h0010_0093_0000_0013, 8);
        run_txn(0, 0);

        // Checksum vectors (ordinary data when the checksum feature is off)
        set_stream(64'hFA03_0201, 4);
        run_txn(0, 0);
        set_stream(64'hFB03_0201, 4);
        run_txn(0, 0);

        // Randomized streams
        for (int t = 0; t < 40; t++) begin
            int n;
            logic [7:0] s;
            n = $urandom_range(1, 10);
            stream.delete();
            s = 8'h00;
            for (int i = 0; i < n; i++) begin
                stream.push_back(8'($urandom));
                if (i < n - 1) s = s + stream[i];
            end
            if ($urandom_range(0, 1) == 1) stream[n - 1] = 8'h00 - s;
            run_txn(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of a load
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back('{addr: AW'(i), data: 8'(8'hA0 + i)});
            send_beat(8'(8'hA0 + i), 1'b0, 1'b1, 1'b0, 1'b0);
        end
        @(negedge clk); #1;
        reset = 1'b0;
        #1;
        check("async reset in_ready", 64'(in_ready), 64'd0);
        check("async reset wr_en", 64'(wr_en), 64'd0);
        check("async reset wr_addr", 64'(wr_addr), 64'd0);
        check("async reset wr_data", 64'(wr_data), 64'd0);
        check("async reset hold_fetch", 64'(hold_fetch), 64'd0);
        check("async reset load_done", 64'(load_done), 64'd0);
        check("async reset load_err", 64'(load_err), 64'd0);
        check("async reset byte_count", 64'(byte_count), 64'd0);
        check("async reset pending writes", 64'(exp_q.size()), 64'd0);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("idle after reset in_ready", 64'(in_ready), 64'd0);
        check("idle after reset hold_fetch", 64'(hold_fetch), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
